// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin search helper for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int UART_DATA_W = 8;
    localparam int MAX_REQ     = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First asserted request at or above ptr, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0] ptr, input int n);
        pick_t p;
        int    i;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            i = int'(ptr) + k;
            if (i >= n) i = i - n;
            if (k < n && !p.found && req[i]) begin
                p.found = 1'b1;
                p.idx   = 3'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin priority search over NUM_REQ request lines.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    pick_t pick;

    assign pick    = rr_pick(MAX_REQ'(req_i), 3'(ptr_i), NUM_REQ);
    assign found_o = pick.found;
    assign idx_o   = IDX_W'(pick.idx);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters: round-robin grant,
// per-message lock, tx_start/tx_done handshake and a watchdog on tx_done.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_DATA_W,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      uart_tx_start,
    output logic [DATA_W-1:0]         uart_tx_data,
    input  logic                      uart_tx_done,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner,
    output logic                      locked,
    output logic                      timeout_err
);

    localparam int               WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic                start_q, last_q, locked_q, terr_q, done_q;
    logic [DATA_W-1:0]   data_q;
    logic [IDX_W-1:0]    owner_q, rr_ptr_q;
    logic [WD_W-1:0]     wd_q;

    logic                pick_found, sel_vld, done_rise;
    logic [IDX_W-1:0]    pick_idx, sel_idx, rr_ptr_d;

    uart_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // A locked owner is served only by itself; dropping its req releases the lock.
    assign sel_vld   = locked_q ? req[owner_q] : pick_found;
    assign sel_idx   = locked_q ? owner_q : pick_idx;
    assign done_rise = uart_tx_done & ~done_q;
    assign rr_ptr_d  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            owner_q  <= '0;
            locked_q <= 1'b0;
            terr_q   <= 1'b0;
            rr_ptr_q <= '0;
            done_q   <= 1'b0;
            wd_q     <= '0;
        end else begin
            done_q  <= uart_tx_done;
            ack_q   <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (locked_q && !req[owner_q]) begin
                        locked_q <= 1'b0;
                    end else if (sel_vld) begin
                        state_q        <= START;
                        data_q         <= req_data[int'(sel_idx)*DATA_W +: DATA_W];
                        last_q         <= req_last[sel_idx];
                        owner_q        <= sel_idx;
                        ack_q[sel_idx] <= 1'b1;
                        start_q        <= 1'b1;
                    end
                end
                START: begin
                    state_q <= WAIT_DONE;
                    wd_q    <= '0;
                end
                WAIT_DONE: begin
                    if (done_rise) begin
                        state_q  <= IDLE;
                        locked_q <= ~last_q;
                        if (last_q) rr_ptr_q <= rr_ptr_d;
                    end else if (wd_q == WD_MAX) begin
                        state_q  <= IDLE;
                        terr_q   <= 1'b1;
                        locked_q <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack           = ack_q;
    assign uart_tx_start = start_q;
    assign uart_tx_data  = data_q;
    assign busy          = (state_q == START) || (state_q == WAIT_DONE);
    assign owner         = owner_q;
    assign locked        = locked_q;
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: queued requesters, a tx_done responder and a start/ack monitor.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int TO  = 100;
    localparam int DLY = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NR-1:0]  req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_last = '0;
    logic [NR-1:0]  ack;
    logic           uart_tx_start;
    logic [DW-1:0]  uart_tx_data;
    logic           uart_tx_done = 1'b0;
    logic           busy;
    logic [1:0]     owner;
    logic           locked;
    logic           timeout_err;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
        .uart_tx_done(uart_tx_done), .busy(busy), .owner(owner), .locked(locked),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    logic [8:0] rq [NR][$];
    logic [7:0] tx_log[$];
    logic       lock_log[$];
    int cyc = 0, pend = 0, ack_cnt = 0, terr_cnt = 0, start_cyc = 0, terr_cyc = 0, stab_err = 0;
    bit resp_en = 1'b1, saw_lock = 1'b0, busy_at_terr = 1'b0;
    logic [7:0] cur_data = '0;

    always @(posedge clk) cyc++;

    // Transmitter model: tx_done pulses DLY cycles after each start unless disabled.
    always @(posedge clk) begin
        #1;
        uart_tx_done = 1'b0;
        if (uart_tx_start) pend = resp_en ? DLY : 0;
        else if (pend > 0) begin
            pend--;
            if (pend == 0) uart_tx_done = 1'b1;
        end
    end

    // Requesters: pop on ack, present the next queued byte (bit 8 = last).
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                req[i]              = 1'b1;
                req_data[i*DW +: DW] = rq[i][0][7:0];
                req_last[i]         = rq[i][0][8];
            end else begin
                req[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            logic [NR-1:0] oh;
            oh = 4'b0001 << owner;
            if (ack != 0 || uart_tx_start) chk("ack_start", {ack, uart_tx_start}, {oh, 1'b1});
            if (uart_tx_start) begin
                tx_log.push_back(uart_tx_data);
                lock_log.push_back(locked);
                start_cyc = cyc;
                cur_data  = uart_tx_data;
            end else if (busy && uart_tx_data != cur_data) stab_err++;
            if (ack != 0) ack_cnt++;
            if (locked) saw_lock = 1'b1;
            if (timeout_err) begin
                terr_cnt++;
                terr_cyc     = cyc;
                busy_at_terr = busy;
            end
        end
    end

    task automatic chk_rst(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ack"}, {ack, uart_tx_start, timeout_err}, 0);
        chk({tag, "_data"}, uart_tx_data, 0);
        chk({tag, "_own"}, {owner, locked}, 0);
    endtask

    task automatic clear_logs();
        tx_log.delete();
        lock_log.delete();
        ack_cnt  = 0;
        saw_lock = 1'b0;
        stab_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 chk_rst("rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            ok = (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() == 0)
                 && !busy && req == 0 && pend == 0;
        end
        chk({tag, "_quiet"}, ok, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_log(input string tag, input int n, input logic [31:0] exp);
        logic [7:0] got;
        chk({tag, "_n"}, tx_log.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), got, exp[(n-1-i)*8 +: 8]);
        end
    endtask

    task automatic chk_locks(input string tag, input int n, input logic [3:0] exp);
        logic [3:0] got;
        got = '0;
        for (int i = 0; i < n && i < lock_log.size(); i++) got[n-1-i] = lock_log[i];
        chk(tag, got, exp);
    endtask

    initial begin
        // Reset held low for 30 ns.
        #25 chk_rst("por");
        #5 rst = 1'b1;
        clear_logs();

        // Single byte.
        @(negedge clk);
        rq[0].push_back({1'b1, 8'h55});
        wait_quiet("single", 100);
        chk_log("single", 1, 32'h55);
        chk("single_acks", ack_cnt, 1);
        chk("single_lock", saw_lock, 0);

        // Fairness from a fresh pointer.
        do_reset();
        for (int i = 0; i < NR; i++) rq[i].push_back({1'b1, 8'hA0 + 8'(i)});
        wait_quiet("fair", 200);
        chk_log("fair", 4, 32'hA0A1A2A3);
        chk("fair_acks", ack_cnt, 4);

        // Message lock: req1's three bytes go out before req3.
        clear_logs();
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b0, 8'h22});
        rq[1].push_back({1'b1, 8'h33});
        rq[3].push_back({1'b1, 8'h44});
        wait_quiet("lock", 200);
        chk_log("lock", 4, 32'h11223344);
        chk_locks("lock_at_start", 4, 4'b0110);
        chk("lock_end", locked, 0);

        // Lock drop: req2 leaves mid-message, pending req0 takes over.
        clear_logs();
        rq[2].push_back({1'b0, 8'h77});
        for (int n = 0; n < 50 && tx_log.size() == 0; n++) @(negedge clk);
        rq[0].push_back({1'b1, 8'h01});
        wait_quiet("drop", 200);
        chk_log("drop", 2, 32'h7701);
        chk("drop_saw_lock", saw_lock, 1);
        chk_locks("drop_at_start", 2, 4'b0000);
        chk("drop_end", locked, 0);

        // Watchdog: START, 100 WAIT_DONE cycles, then the error pulse.
        clear_logs();
        resp_en = 1'b0;
        rq[0].push_back({1'b1, 8'h5A});
        for (int n = 0; n < 400 && terr_cnt == 0; n++) @(negedge clk);
        chk("to_cnt", terr_cnt, 1);
        chk("to_delay", terr_cyc - start_cyc, TO + 1);
        chk("to_idle", busy_at_terr, 0);
        resp_en = 1'b1;
        rq[1].push_back({1'b1, 8'hC3});
        wait_quiet("to", 200);
        chk_log("to", 2, 32'h5AC3);
        chk("to_once", terr_cnt, 1);

        // Asynchronous reset in WAIT_DONE, then the byte is re-presented.
        clear_logs();
        rq[2].push_back({1'b1, 8'h9C});
        for (int n = 0; n < 50 && !(busy && !uart_tx_start); n++) @(negedge clk);
        chk("mid_busy", busy, 1);
        #1 rst = 1'b0;
        #1 chk_rst("mid");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        clear_logs();
        rq[2].push_back({1'b1, 8'h9C});
        wait_quiet("retx", 100);
        chk_log("retx", 1, 32'h9C);
        chk("retx_own", owner, 2);
        chk("stable", stab_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "bench hung");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter inside uart_top between NUM_REQ byte requesters.
- Round-robin arbitration between requesters.
- Message locking: one requester keeps the transmitter across a multi-byte message, so messages never interleave.
- Sequences the transmitter: one-cycle tx_start, data held stable, completion detected on the rising edge of tx_done, watchdog on a missing tx_done.
- Sits between client logic and the uart_top tx_start/tx_data/tx_done ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, UART byte width
TIMEOUT_CYCLES, 65535, maximum clk cycles in WAIT_DONE before abort (one 9600-baud frame at 50 MHz is about 52080)
IDX_W, $clog2(NUM_REQ), owner index width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester byte request; held until ack
req_data  input  NUM_REQ*DATA_W  byte of requester i in bits [i*DATA_W +: DATA_W]
req_last  input  NUM_REQ  byte is the final byte of its message
ack  output  NUM_REQ  one-hot, one-cycle pulse when the byte is accepted
uart_tx_start  output  1  one-cycle start pulse to uart_top tx_start
uart_tx_data  output  DATA_W  byte to uart_top tx_data; stable from START to end of WAIT_DONE
uart_tx_done  input  1  uart_top tx_done (level or pulse)
busy  output  1  high in START or WAIT_DONE
owner  output  IDX_W  index of the current or last granted requester
locked  output  1  message lock held by owner
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ack=0, uart_tx_start=0, uart_tx_data=0, busy=0, owner=0, locked=0, timeout_err=0, rr_ptr=0, done_q=0, watchdog=0.
- Done detection: done_q registers uart_tx_done every cycle; done_rise = uart_tx_done & ~done_q.
- IDLE
  - If locked and req[owner]=1: select owner.
  - If locked and req[owner]=0: clear locked this edge; arbitrate from the next cycle.
  - If unlocked: select the first asserted req searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... NUM_REQ-1, 0, ...).
  - On a selection: go to START; capture req_data of the winner into uart_tx_data and req_last into last_q; owner=winner.
- START (exactly one cycle): ack[owner]=1, uart_tx_start=1, busy=1, watchdog cleared. Always go to WAIT_DONE.
- WAIT_DONE
  - Watchdog increments each cycle.
  - done_rise: go to IDLE.
    - last_q=1: locked=0 and rr_ptr=owner+1 (wrapping at NUM_REQ).
    - last_q=0: locked=1 and rr_ptr unchanged.
  - watchdog==TIMEOUT_CYCLES-1 with no done_rise: timeout_err=1 for one cycle, locked=0, rr_ptr=owner+1, go to IDLE.
  - Both in the same cycle: done_rise wins and no error is raised.
- Latency: req high before edge k gives ack and uart_tx_start high in cycle k+1. The next START is at least 2 cycles after done_rise.
- Requester rules:
  - req_data[i] and req_last[i] must be stable while req[i]=1 and ack[i]=0.
  - The requester may present its next byte in the cycle after ack.
  - Changes to req during START or WAIT_DONE are ignored.
- done_rise outside WAIT_DONE is ignored.
- A reset mid-transfer aborts immediately. No ack is reissued, and the requester must re-present the byte.

Decomposition:
- Package uart_arb_pkg:
  - state enum {IDLE, START, WAIT_DONE}
  - DATA_W default
  - function rr_pick(req, ptr), returning found flag and index
- Sub-module uart_rr_picker: combinational round-robin priority search, parameterised by NUM_REQ.

Test Plan:
- Single byte. Reset low 30 ns then release; req[0]=1 with data 8'h55, last=1.
  -> ack[0] pulse and uart_tx_start pulse in the same cycle; uart_tx_data=8'h55.
  -> uart_top rx_out=8'h55 at rx_done; locked stays 0.
- Fairness. req=4'b1111, all last=1, data 8'hA0..8'hA3.
  -> grant order 0,1,2,3 (bytes A0,A1,A2,A3); rx_out sequence matches; exactly one ack per byte.
- Message lock.
  - Req1 sends 3 bytes 8'h11,8'h22,8'h33 with last on the third.
  - req3 is held high from the start with 8'h44, last=1.
  -> tx order 11,22,33,44; locked=1 between bytes 1-3; 0 after 33.
- Lock drop. Req2 sends 8'h77 with last=0, then deasserts req.
  -> locked clears in IDLE; a pending req0 byte 8'h01 is granted next.
- Timeout. TIMEOUT_CYCLES=100; uart_tx_done forced 0; req0 byte 8'h5A.
  -> timeout_err pulse exactly 100 cycles after START; back in IDLE; a following req1 byte is granted.
- Reset mid-operation. rst=0 during WAIT_DONE.
  -> all outputs at reset values the same cycle (asynchronous); after release, the re-presented byte is transmitted normally.
